// File: rtl/uart_sched_pkg.sv
// Shared types and frame constants for the UART TX scheduler.
// Frame length depends on UART_SCHED_PARITY_EN.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;

`ifdef UART_SCHED_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/line bundle between the channel requesters and the scheduler.
interface uart_tx_scheduler_if #(
    parameter int N_CH = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   req;
    logic [8*N_CH-1:0] data;
    logic [N_CH-1:0]   ack;
    logic              busy;
    logic [CH_W-1:0]   cur_ch;
    logic [N_CH-1:0]   tx;

    modport master (output req, data, input ack, busy, cur_ch, tx);
    modport slave  (input req, data, output ack, busy, cur_ch, tx);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic                  grant_valid,
    output logic [$clog2(N)-1:0]  grant_idx
);
    localparam int W = $clog2(N);

    logic [W:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (W+1)'(i);
            if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
            if (!grant_valid && req[idx[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[W-1:0];
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART serializer across N_CH per-channel TX lines.
// Optional even parity bit when UART_SCHED_PARITY_EN is defined.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_scheduler_if.slave bus
);
    localparam int          CH_W      = $clog2(N_CH);
    localparam int          BIT_W     = $clog2(FRAME_BITS);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t                 state_q, state_n;
    logic [15:0]            baud_q, baud_n;
    logic [BIT_W-1:0]       bit_q, bit_n;
    logic [DATA_BITS-1:0]   shreg_q, shreg_n;
    logic [CH_W-1:0]        ch_q, ch_n, ptr_q, ptr_n;
    logic [N_CH-1:0]        ack_q, ack_n, tx_q, tx_n;
    logic                   busy_q, busy_n;
    logic                   grant_valid;
    logic [CH_W-1:0]        grant_idx;
    logic                   tc;
`ifdef UART_SCHED_PARITY_EN
    logic                   par_q, par_n;
`endif

    rr_arbiter #(.N(N_CH)) u_arb (
        .req         (bus.req),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign tc = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            tx_q    <= '1;
            busy_q  <= 1'b0;
`ifdef UART_SCHED_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shreg_q <= shreg_n;
            ch_q    <= ch_n;
            ptr_q   <= ptr_n;
            ack_q   <= ack_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
`ifdef UART_SCHED_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // bit_q counts frame bits (0 = start); shreg_q shifts right so bit 0 is always on the line.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        ch_n    = ch_q;
        ptr_n   = ptr_q;
        ack_n   = '0;
`ifdef UART_SCHED_PARITY_EN
        par_n   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_n          = START;
                    baud_n           = '0;
                    bit_n            = '0;
                    shreg_n          = bus.data[8*grant_idx +: 8];
                    ch_n             = grant_idx;
                    ptr_n            = (grant_idx == CH_W'(N_CH - 1)) ? '0 : CH_W'(grant_idx + 1'b1);
                    ack_n[grant_idx] = 1'b1;
`ifdef UART_SCHED_PARITY_EN
                    par_n            = ^bus.data[8*grant_idx +: 8];
`endif
                end
            end
            default: begin
                baud_n = tc ? '0 : baud_q + 16'd1;
                if (tc) begin
                    bit_n = bit_q + 1'b1;
                    case (state_q)
                        START: state_n = DATA;
                        DATA: begin
                            if (bit_q == BIT_W'(DATA_BITS)) begin
`ifdef UART_SCHED_PARITY_EN
                                state_n = PARITY;
`else
                                state_n = STOP;
`endif
                            end else begin
                                shreg_n = shreg_q >> 1;
                            end
                        end
                        PARITY: state_n = STOP;
                        default: begin
                            state_n = IDLE;
                            bit_n   = '0;
                        end
                    endcase
                end
            end
        endcase
    end

    // Line values are computed from next-state values so tx is a plain register.
    always_comb begin
        tx_n   = '1;
        busy_n = (state_n != IDLE);
        case (state_n)
            START: tx_n[ch_n] = 1'b0;
            DATA:  tx_n[ch_n] = shreg_n[0];
`ifdef UART_SCHED_PARITY_EN
            PARITY: tx_n[ch_n] = par_n;
`endif
            default: ;
        endcase
    end

    assign bus.ack    = ack_q;
    assign bus.tx     = tx_q;
    assign bus.busy   = busy_q;
    assign bus.cur_ch = ch_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_CH=8, CLKS_PER_BIT=4).
module tb_uart_tx_scheduler;
    localparam int N   = 8;
    localparam int CPB = 4;
`ifdef UART_SCHED_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_CH(N)) bus ();

    uart_tx_scheduler #(.N_CH(N), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Expected tx vector at cycle cyc (0-based from the grant) of a frame on channel ch.
    function automatic logic [7:0] exp_line(input int ch, input logic [7:0] d, input int cyc);
        int b;
        logic v;
        logic [7:0] r;
        b = cyc / CPB;
        if (b == 0) v = 1'b0;
        else if (b <= 8) v = d[b-1];
        else if (FB == 11 && b == 9) v = ^d;
        else v = 1'b1;
        r = 8'hFF;
        r[ch] = v;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.busy, bus.ack, bus.cur_ch} !== {8'hFF, 1'b0, 8'h00, 3'd0}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d: tx=%h busy=%b ack=%h cur_ch=%0d, expected tx=ff busy=0 ack=00 cur_ch=0",
                         i, bus.tx, bus.busy, bus.ack, bus.cur_ch);
            end
        end
    endtask

    task automatic test_single();
        bus.data[8*3 +: 8] = 8'hA5;
        bus.req = 8'h08;
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus.req = '0;
            checks++;
            if (bus.tx !== exp_line(3, 8'hA5, cyc)) begin
                failures++;
                $display("FAIL single_tx cyc=%0d: got %h expected %h", cyc, bus.tx, exp_line(3, 8'hA5, cyc));
            end
            checks++;
            if ({bus.ack, bus.busy, bus.cur_ch} !== {(cyc == 0) ? 8'h08 : 8'h00, 1'b1, 3'd3}) begin
                failures++;
                $display("FAIL single_ctl cyc=%0d: ack=%h busy=%b cur_ch=%0d expected ack=%h busy=1 cur_ch=3",
                         cyc, bus.ack, bus.busy, bus.cur_ch, (cyc == 0) ? 8'h08 : 8'h00);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.ack} !== {8'hFF, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL single_end: tx=%h busy=%b ack=%h expected tx=ff busy=0 ack=00", bus.tx, bus.busy, bus.ack);
        end
    endtask

    task automatic test_all_channels();
        do_reset();
        for (int i = 0; i < N; i++) bus.data[8*i +: 8] = 8'(i);
        bus.req = 8'hFF;
        for (int f = 0; f < 9; f++) begin
            for (int cyc = 0; cyc < FRAME; cyc++) begin
                @(negedge clk);
                checks++;
                if (bus.tx !== exp_line(f % N, 8'(f % N), cyc)) begin
                    failures++;
                    $display("FAIL all_tx frame=%0d cyc=%0d: got %h expected %h", f, cyc, bus.tx, exp_line(f % N, 8'(f % N), cyc));
                end
                checks++;
                if ({bus.ack, bus.cur_ch} !== {(cyc == 0) ? 8'(1 << (f % N)) : 8'h00, 3'(f % N)}) begin
                    failures++;
                    $display("FAIL all_grant frame=%0d cyc=%0d: ack=%h cur_ch=%0d expected cur_ch=%0d",
                             f, cyc, bus.ack, bus.cur_ch, f % N);
                end
            end
            @(negedge clk);
            if (f == 8) bus.req = '0;
            checks++;
            if ({bus.tx, bus.busy} !== {8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL all_gap frame=%0d: tx=%h busy=%b expected tx=ff busy=0", f, bus.tx, bus.busy);
            end
        end
    endtask

    task automatic test_rr_pointer();
        int        chs[3];
        logic [7:0] req_ack[3];
        logic [7:0] req_gap[3];
        logic [7:0] d;
        chs     = '{4, 5, 0};
        req_ack = '{8'h00, 8'h01, 8'h00};
        req_gap = '{8'h21, 8'h01, 8'h00};
        do_reset();
        for (int i = 0; i < N; i++) bus.data[8*i +: 8] = 8'(8'h3C ^ i);
        bus.req = 8'h10;
        for (int f = 0; f < 3; f++) begin
            d = 8'(8'h3C ^ chs[f]);
            for (int cyc = 0; cyc < FRAME; cyc++) begin
                @(negedge clk);
                if (cyc == 0) bus.req = req_ack[f];
                checks++;
                if ({bus.tx, bus.cur_ch} !== {exp_line(chs[f], d, cyc), 3'(chs[f])}) begin
                    failures++;
                    $display("FAIL rr_frame frame=%0d cyc=%0d: tx=%h cur_ch=%0d expected tx=%h cur_ch=%0d",
                             f, cyc, bus.tx, bus.cur_ch, exp_line(chs[f], d, cyc), chs[f]);
                end
            end
            @(negedge clk);
            bus.req = req_gap[f];
            checks++;
            if ({bus.tx, bus.busy} !== {8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL rr_gap frame=%0d: tx=%h busy=%b expected tx=ff busy=0", f, bus.tx, bus.busy);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        bus.data[8*2 +: 8] = 8'hC3;
        bus.data[8*4 +: 8] = 8'h5A;
        bus.req = 8'h04;
        for (int cyc = 0; cyc < 22; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus.req = '0;
            checks++;
            if (bus.tx !== exp_line(2, 8'hC3, cyc)) begin
                failures++;
                $display("FAIL mid_tx cyc=%0d: got %h expected %h", cyc, bus.tx, exp_line(2, 8'hC3, cyc));
            end
        end
        // Abort during data bit 4; ch 4 would win if the pointer (3) survived reset.
        rst_n = 1'b0;
        bus.req = 8'h14;
        @(negedge clk);
        checks++;
        if ({bus.tx, bus.busy, bus.cur_ch, bus.ack} !== {8'hFF, 1'b0, 3'd0, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset: tx=%h busy=%b cur_ch=%0d ack=%h expected tx=ff busy=0 cur_ch=0 ack=00",
                     bus.tx, bus.busy, bus.cur_ch, bus.ack);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.req = '0;
        checks++;
        if ({bus.ack, bus.cur_ch, bus.tx, bus.busy} !== {8'h04, 3'd2, 8'hFB, 1'b1}) begin
            failures++;
            $display("FAIL mid_regrant: ack=%h cur_ch=%0d tx=%h busy=%b expected ack=04 cur_ch=2 tx=fb busy=1",
                     bus.ack, bus.cur_ch, bus.tx, bus.busy);
        end
    endtask

    task automatic test_parity();
        logic [7:0] vals[2];
        vals = '{8'h07, 8'h03};
        for (int v = 0; v < 2; v++) begin
            do_reset();
            bus.data[8*1 +: 8] = vals[v];
            bus.req = 8'h02;
            for (int cyc = 0; cyc < FRAME; cyc++) begin
                @(negedge clk);
                if (cyc == 0) bus.req = '0;
                checks++;
                if (bus.tx !== exp_line(1, vals[v], cyc)) begin
                    failures++;
                    $display("FAIL parity_tx data=%h cyc=%0d: got %h expected %h", vals[v], cyc, bus.tx, exp_line(1, vals[v], cyc));
                end
            end
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.busy} !== {8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL parity_end data=%h: tx=%h busy=%b expected tx=ff busy=0", vals[v], bus.tx, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_rr_pointer();
        test_reset_midframe();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
